// File: rtl/byte_striping_pkg.sv
// byte_striping_pkg: lane count, byte width, FSM state and lane index types shared by striper and unstriper
package byte_striping_pkg;
  localparam int LANES = 4;
  localparam int DATA_W_DEF = 8;
  typedef enum logic {IDLE, RUN} state_e;
  typedef logic [1:0] lane_t;
endpackage

// File: rtl/lane_fifo.sv
// lane_fifo: per-lane synchronous FIFO with extra pointer bit for full/empty, no write-to-read bypass
module lane_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, rd_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o = mem_q[rd_q[AW-1:0]];
  // read/write pointers; a pop frees the full slot so a same-cycle push is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
  // storage array, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/byte_unstriping.sv
// byte_unstriping: reassembles four skewed lanes into one byte stream; UNSTRIPE_HOLD_LAST_EN holds last byte when idle
module byte_unstriping
  import byte_striping_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic              clk1Mhz,
  input  logic              reset,
  input  logic [DATA_W-1:0] stripedLane0,
  input  logic [DATA_W-1:0] stripedLane1,
  input  logic [DATA_W-1:0] stripedLane2,
  input  logic [DATA_W-1:0] stripedLane3,
  input  logic              lane0VLD,
  input  logic              lane1VLD,
  input  logic              lane2VLD,
  input  logic              lane3VLD,
  output logic [DATA_W-1:0] unstripedOUT,
  output logic              unstripedVLD,
  output logic [1:0]        counter,
  output logic              overflow
);
  logic [DATA_W-1:0] lane_data [LANES];
  logic [DATA_W-1:0] fifo_dout [LANES];
  logic [LANES-1:0] push, pop, full, empty;
  state_e state_q, state_d;
  lane_t cnt_q, cnt_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic vld_q, vld_d, ovf_q, ovf_d;
  assign lane_data[0] = stripedLane0;
  assign lane_data[1] = stripedLane1;
  assign lane_data[2] = stripedLane2;
  assign lane_data[3] = stripedLane3;
  assign push = {lane3VLD, lane2VLD, lane1VLD, lane0VLD};
  assign unstripedOUT = out_q;
  assign unstripedVLD = vld_q;
  assign counter = cnt_q;
  assign overflow = ovf_q;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk1Mhz),
      .rst_n  (reset),
      .push_i (push[g]),
      .pop_i  (pop[g]),
      .data_i (lane_data[g]),
      .data_o (fifo_dout[g]),
      .full_o (full[g]),
      .empty_o(empty[g])
    );
  end
  // align on all lanes non-empty, then pop strictly round-robin, stalling on an empty lane
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pop = '0;
    vld_d = 1'b0;
`ifdef UNSTRIPE_HOLD_LAST_EN
    out_d = out_q;
`else
    out_d = '0;
`endif
    case (state_q)
      IDLE: state_d = |empty ? IDLE : RUN;
      RUN: begin
        if (cnt_q == 2'd0 && &empty) state_d = IDLE;
        else if (!empty[cnt_q]) begin
          pop[cnt_q] = 1'b1;
          out_d = fifo_dout[cnt_q];
          vld_d = 1'b1;
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    ovf_d = ovf_q | (|(push & full & ~pop));
  end
  // registered outputs and FSM state
  always_ff @(posedge clk1Mhz or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      vld_q <= vld_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_byte_unstriping.sv
// tb_byte_unstriping: randomized and directed stimulus against a queue-based reference of the unstriper
module tb_byte_unstriping;
  localparam int DEPTH = 4;
`ifdef UNSTRIPE_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] ld [4];
  logic [3:0] lv = '0;
  logic [7:0] dut_out;
  logic dut_vld, dut_ovf;
  logic [1:0] dut_cnt;
  int n_chk = 0, n_pass = 0;
  logic [7:0] mq [4][$];
  bit m_run = 0, m_vld = 0, m_ovf = 0;
  int m_lane = 0;
  logic [7:0] m_out = '0;

  always #5 clk = ~clk;

  byte_unstriping dut (
    .clk1Mhz     (clk),
    .reset       (rst_n),
    .stripedLane0(ld[0]),
    .stripedLane1(ld[1]),
    .stripedLane2(ld[2]),
    .stripedLane3(ld[3]),
    .lane0VLD    (lv[0]),
    .lane1VLD    (lv[1]),
    .lane2VLD    (lv[2]),
    .lane3VLD    (lv[3]),
    .unstripedOUT(dut_out),
    .unstripedVLD(dut_vld),
    .counter     (dut_cnt),
    .overflow    (dut_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_vld"}, 32'(dut_vld), 32'(m_vld));
    check({tag, "_cnt"}, 32'(dut_cnt), 32'(m_lane));
    check({tag, "_ovf"}, 32'(dut_ovf), 32'(m_ovf));
    check({tag, "_out"}, 32'(dut_out), 32'(m_out));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_run = 0; m_vld = 0; m_ovf = 0; m_lane = 0; m_out = '0;
  endtask

  task automatic model_edge();
    bit all_empty, all_full_occ;
    all_empty = 1; all_full_occ = 1;
    for (int i = 0; i < 4; i++) begin
      if (mq[i].size() != 0) all_empty = 0;
      else all_full_occ = 0;
    end
    m_vld = 0;
    if (m_run) begin
      if (m_lane == 0 && all_empty) m_run = 0;
      else if (mq[m_lane].size() != 0) begin
        m_out = mq[m_lane].pop_front();
        m_vld = 1;
        m_lane = (m_lane + 1) % 4;
      end
    end else if (all_full_occ) m_run = 1;
    if (!m_vld && !HOLD) m_out = '0;
    for (int i = 0; i < 4; i++)
      if (lv[i]) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(ld[i]);
        else m_ovf = 1;
      end
  endtask

  task automatic cyc(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                     input logic [7:0] d2, input logic [7:0] d3, input string tag);
    lv = v; ld[0] = d0; ld[1] = d1; ld[2] = d2; ld[3] = d3;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, tag);
  endtask

  task automatic do_reset(input string tag);
    lv = '0;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) ld[i] = '0;
    #3;
    model_clear();
    check_all("reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    cyc(4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3, "aligned");
    idle(7, "aligned");

    cyc(4'hB, 8'h10, 8'h11, 8'h00, 8'h13, "skew");
    idle(2, "skew");
    cyc(4'h4, 8'h00, 8'h00, 8'h12, 8'h00, "skew");
    idle(7, "skew");

    for (int f = 0; f < 4; f++) begin
      cyc(4'hF, 8'(8'h20 + 4 * f), 8'(8'h21 + 4 * f), 8'(8'h22 + 4 * f), 8'(8'h23 + 4 * f), "stripe");
      idle(3, "stripe");
    end
    idle(3, "stripe");

    cyc(4'hF, 8'h40, 8'h41, 8'h42, 8'h43, "under");
    idle(3, "under");
    cyc(4'h7, 8'h44, 8'h45, 8'h46, 8'h00, "under");
    idle(3, "under");
    cyc(4'h7, 8'h48, 8'h49, 8'h4A, 8'h00, "under");
    idle(4, "under");
    check("under_stall_cnt", 32'(dut_cnt), 32'd3);
    check("under_stall_vld", 32'(dut_vld), 32'd0);
    cyc(4'h8, 8'h00, 8'h00, 8'h00, 8'h47, "under");
    cyc(4'h8, 8'h00, 8'h00, 8'h00, 8'h4B, "under");
    idle(8, "under");

    cyc(4'hF, 8'h50, 8'h51, 8'h52, 8'h53, "midrst");
    cyc(4'hF, 8'h54, 8'h55, 8'h56, 8'h57, "midrst");
    do_reset("midrst_now");
    idle(6, "midrst_after");

    for (int i = 0; i < 5; i++) cyc(4'h2, 8'h00, 8'(8'h60 + i), 8'h00, 8'h00, "ovf");
    check("ovf_set", 32'(dut_ovf), 32'd1);
    idle(4, "ovf_hold");
    check("ovf_lane1_occ", 32'(mq[1].size()), 32'd4);
    cyc(4'hD, 8'h70, 8'h00, 8'h72, 8'h73, "ovf_drain");
    idle(8, "ovf_drain");
    do_reset("ovf_clr");

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 120; i++) begin
        logic [3:0] v;
        int mode;
        mode = r % 2;
        v = mode == 0 ? ((i % 4 == 0) ? 4'hF : 4'h0) : 4'($urandom_range(0, 15) & $urandom_range(0, 15));
        if (mode == 0 && $urandom_range(0, 7) == 0) v = 4'($urandom_range(0, 15));
        cyc(v, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), "rand");
      end
      do_reset("rand_rst");
      @(posedge clk); #1;
      model_edge();
      check_all("rand_post");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/byte_unstriping.md
# byte_unstriping

Reassembles the four striped lanes back into a single byte stream. It sits directly downstream of the byte striper and consumes its `stripedLaneN` / `laneNVLD` outputs. It buffers each lane in a small FIFO to absorb inter-lane skew, aligns on the first complete set of four bytes, then emits bytes round-robin lane0→lane3 at the fast clock rate. The block runs entirely in the `clk1Mhz` domain.

## Interface
- `DATA_W`, 8, byte width of every lane and of the output
- `DEPTH`, 4, entries per lane FIFO (power of two, ≥2)
- `clk1Mhz`  in  1  sole clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `stripedLane0`..`stripedLane3`  in  DATA_W  lane data
- `lane0VLD`..`lane3VLD`  in  1  lane data valid; each high cycle writes one byte into that lane's FIFO
- `unstripedOUT`  out  DATA_W  reassembled byte (registered)
- `unstripedVLD`  out  1  `unstripedOUT` holds a valid byte this cycle (registered)
- `counter`  out  2  lane to be read next (registered)
- `overflow`  out  1  sticky: a write hit a full lane FIFO

## Operation
- **Reset values:** all outputs 0; FSM in IDLE; all FIFOs empty; `counter`=0.
- **Lane FIFOs:** one per lane, written when `laneNVLD`=1.
  - Write to a full FIFO: byte dropped, `overflow` set; it stays set until reset.
  - Full FIFO with a pop and a push in the same cycle: both happen, no overflow.
  - No bypass: a byte written into an empty FIFO is poppable the following cycle.
- **FSM states:** IDLE, RUN.
  - IDLE: no pops, `unstripedVLD`=0, `counter` held at 0. Go to RUN when all four FIFOs are non-empty.
  - RUN, FIFO[`counter`] non-empty: pop it, register the byte on `unstripedOUT`, set `unstripedVLD`=1, advance `counter` mod 4 (3→0 wraps).
  - RUN, FIFO[`counter`] empty: stall. `unstripedVLD`=0, `counter` held, stay in RUN.
  - RUN, `counter`=0 and all four FIFOs empty: return to IDLE (frame boundary, realign).
- **Ordering:** output order is always lane0, lane1, lane2, lane3, repeating. Lanes are never skipped.
- **Reset mid-operation:** asserting `reset` clears everything immediately (async). Buffered bytes are lost.

## Timing
- The IDLE→RUN decision uses FIFO occupancy after edge E, where E is the edge writing the last lane's first byte. The FSM enters RUN at E+1.
- The lane0 byte is visible on the outputs after E+2. Latency: 2 edges.
- In steady RUN, output is one byte per cycle. Occupancy check and pop happen in the same cycle.
- With the striper feeding all four lanes together every 4th cycle: output is 4 consecutive valid cycles per 4-cycle window, with zero net FIFO growth.

## Configuration
- Macro: `UNSTRIPE_HOLD_LAST_EN`.
- **Defined:** when `unstripedVLD`=0, `unstripedOUT` holds the last valid byte.
- **Undefined:** when `unstripedVLD`=0, `unstripedOUT` is driven to 0.
- `unstripedVLD`, `counter` and `overflow` behave identically in both builds.

## Structure
- **Shared package `byte_striping_pkg`:** `LANES`=4, `DATA_W` default, the FSM state typedef (IDLE, RUN), and the lane index type (2 bits). The striper uses the same package.
- **Sub-module `lane_fifo`:** synchronous FIFO, instantiated 4×.
  - Ports: clock, reset, push, pop, data in, data out, full, empty.
  - Pointers of width log2(`DEPTH`)+1 for full/empty detection.

## Test plan
- **Aligned lanes:** all four VLD high together with A0/A1/A2/A3 → `unstripedOUT` = A0, A1, A2, A3 on 4 consecutive cycles starting 2 edges later; `counter` 0,1,2,3,0.
- **Skewed lanes:** lane2 arrives 3 cycles after the others (bytes 10, 11, 12, 13) → no output until lane2 is written, then 10, 11, 12, 13 consecutively.
- **Mid-frame underrun:** lane3 stops after frame 1 while lanes 0–2 continue → lanes 0–2 bytes output, then stall with `counter`=3 and `unstripedVLD`=0 until lane3 resumes.
- **Overflow:** 5 writes to lane1 with no pops (lane0 never written) → `overflow`=1 after the 5th write; FIFO holds the first 4 bytes; `overflow` stays 1.
- **Reset mid-run:** pull `reset` low while 2 bytes/lane are buffered → outputs 0 immediately; after release, FSM is in IDLE and old data is never emitted.
- **Macro check:** during a stall, `unstripedOUT` equals the last byte (`UNSTRIPE_HOLD_LAST_EN` defined) or 8'h00 (undefined).
